// File: rtl/index_selector_debounced_pkg.sv
// Shared types and helpers for the debounced switch-to-index selector.
// Encoder helpers work on a fixed maximum width; callers zero-extend and truncate.
package index_sel_pkg;

    localparam int MAX_W     = 64;
    localparam int MAX_IDX_W = $clog2(MAX_W);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } deb_state_e;

    function automatic int cnt_width(input int debounce);
        return (debounce < 1) ? 1 : $clog2(debounce + 1);
    endfunction

    // Later assignments win, so the scan direction picks the priority.
    function automatic logic [MAX_IDX_W-1:0] prio_encode(input logic [MAX_W-1:0] vec,
                                                         input logic high_first);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        if (high_first) begin
            for (int i = 0; i < MAX_W; i++) begin
                if (vec[i]) idx = MAX_IDX_W'(i);
            end
        end else begin
            for (int i = MAX_W - 1; i >= 0; i--) begin
                if (vec[i]) idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [MAX_W-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/index_selector_debounced_if.sv
// Switch input and encoded selection outputs of the index selector.
interface index_selector_debounced_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0] switches;
    logic [IDX_W-1:0] index;
    logic             valid;
    logic             multi;
    logic             none;
    logic             changed;

    modport master (output switches, input index, valid, multi, none, changed);
    modport slave  (input switches, output index, valid, multi, none, changed);
endinterface

// File: rtl/index_selector_debounced_switch_debouncer.sv
// Two-flop synchroniser plus whole-vector debouncer; strobes commit on the
// edge where the candidate has been stable for DEBOUNCE cycles.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SETTLE | candidate differs from committed history, counting stability
// ST_STABLE | candidate committed, waiting for the next input change
module switch_debouncer
    import index_sel_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switches_i,
    output logic [WIDTH-1:0] cand_o,
    output logic [WIDTH-1:0] comm_o,
    output logic             commit_o
);

    localparam int             CNT_W   = cnt_width(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] comm_q, comm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    deb_state_e       state_q, state_d;
    logic             commit;

    always_comb begin
        s1_d    = switches_i;
        s2_d    = s1_q;
        cand_d  = cand_q;
        comm_d  = comm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        commit  = 1'b0;
        // A change on s2 always restarts, even on what would be the commit edge.
        if (s2_q != cand_q) begin
            cand_d  = s2_q;
            cnt_d   = '0;
            state_d = ST_SETTLE;
        end else if (state_q == ST_SETTLE) begin
            if (cnt_q == CNT_MAX) begin
                commit  = 1'b1;
                comm_d  = cand_q;
                state_d = ST_STABLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            comm_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_STABLE;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cand_q  <= cand_d;
            comm_q  <= comm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign cand_o   = cand_q;
    assign comm_o   = comm_q;
    assign commit_o = commit;

endmodule

// File: rtl/index_selector_debounced.sv
// Debounced priority encoder for the ALU front-panel select switches.
// Index and flags are registered on the commit edge of the debouncer.
module index_selector_debounced
    import index_sel_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEBOUNCE   = 16,
    parameter int HIGH_FIRST = 1,
    parameter int STRICT     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    index_selector_debounced_if.slave   sel_if
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] comm;
    logic             commit;

    logic [IDX_W-1:0] index_q, index_d;
    logic             valid_q, valid_d;
    logic             multi_q, multi_d;
    logic             none_q, none_d;
    logic             changed_q, changed_d;
    logic             cand_oh;
    logic             cand_zero;

    switch_debouncer #(
        .WIDTH    (WIDTH),
        .DEBOUNCE (DEBOUNCE)
    ) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .switches_i (sel_if.switches),
        .cand_o     (cand),
        .comm_o     (comm),
        .commit_o   (commit)
    );

    always_comb begin
        cand_oh   = is_onehot(MAX_W'(cand));
        cand_zero = (cand == '0);
        index_d   = index_q;
        valid_d   = valid_q;
        multi_d   = multi_q;
        none_d    = none_q;
        changed_d = commit && (cand != comm);
        if (commit) begin
            none_d  = cand_zero;
            valid_d = cand_oh;
            multi_d = !cand_zero && !cand_oh;
            // Zero (and, when strict, multi-hot) vectors keep the last good index.
            if (!cand_zero && ((STRICT == 0) || cand_oh)) begin
                index_d = IDX_W'(prio_encode(MAX_W'(cand), HIGH_FIRST != 0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_q   <= '0;
            valid_q   <= 1'b0;
            multi_q   <= 1'b0;
            none_q    <= 1'b1;
            changed_q <= 1'b0;
        end else begin
            index_q   <= index_d;
            valid_q   <= valid_d;
            multi_q   <= multi_d;
            none_q    <= none_d;
            changed_q <= changed_d;
        end
    end

    assign sel_if.index   = index_q;
    assign sel_if.valid   = valid_q;
    assign sel_if.multi   = multi_q;
    assign sel_if.none    = none_q;
    assign sel_if.changed = changed_q;

endmodule

// File: tb/tb_index_selector_debounced.sv
// Directed bench: three selector variants (high-first, low-first, strict)
// share one switch stimulus with DEBOUNCE=4.
module tb_index_selector_debounced;

    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    index_selector_debounced_if #(.WIDTH(W)) if_a ();
    index_selector_debounced_if #(.WIDTH(W)) if_b ();
    index_selector_debounced_if #(.WIDTH(W)) if_c ();

    index_selector_debounced #(.WIDTH(W), .DEBOUNCE(D), .HIGH_FIRST(1), .STRICT(0))
        dut_a (.clk(clk), .rst(rst), .sel_if(if_a.slave));
    index_selector_debounced #(.WIDTH(W), .DEBOUNCE(D), .HIGH_FIRST(0), .STRICT(0))
        dut_b (.clk(clk), .rst(rst), .sel_if(if_b.slave));
    index_selector_debounced #(.WIDTH(W), .DEBOUNCE(D), .HIGH_FIRST(1), .STRICT(1))
        dut_c (.clk(clk), .rst(rst), .sel_if(if_c.slave));

    int n_vec = 0;
    int n_bad = 0;
    int chg_a = 0, chg_b = 0, chg_c = 0;
    logic prev_chg_a = 1'b0;
    logic consec = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sw(input logic [W-1:0] v);
        if_a.switches = v;
        if_b.switches = v;
        if_c.switches = v;
    endtask

    task automatic clr_chg();
        chg_a = 0;
        chg_b = 0;
        chg_c = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_idx_a"}, 32'(if_a.index), 32'd0);
        chk({tag, "_flags_a"}, {28'd0, if_a.valid, if_a.multi, if_a.none, if_a.changed}, 32'b0010);
        chk({tag, "_flags_b"}, {28'd0, if_b.valid, if_b.multi, if_b.none, if_b.changed}, 32'b0010);
        chk({tag, "_flags_c"}, {28'd0, if_c.valid, if_c.multi, if_c.none, if_c.changed}, 32'b0010);
    endtask

    always @(posedge clk) begin
        #1;
        if (if_a.changed) chg_a++;
        if (if_b.changed) chg_b++;
        if (if_c.changed) chg_c++;
        if (if_a.changed && prev_chg_a) consec = 1'b1;
        prev_chg_a = if_a.changed;
    end

    initial begin
        logic [2:0] exp_prev;
        set_sw(8'h00);
        rst = 1'b1;
        step(2);
        chk_reset_vals("rst");
        rst = 1'b0;
        step(4);

        // Short glitch returns to zero: nothing may move.
        clr_chg();
        set_sw(8'h10);
        step(2);
        set_sw(8'h00);
        for (int i = 0; i < 14; i++) begin
            step(1);
            chk("glitch_none", 32'(if_a.none), 32'd1);
            chk("glitch_idx", 32'(if_a.index), 32'd0);
        end
        chk("glitch_chg", 32'(chg_a), 32'd0);

        // Walking one: outputs move exactly D+3 edges after the change.
        exp_prev = 3'd0;
        for (int i = 0; i < W; i++) begin
            clr_chg();
            set_sw(W'(1) << i);
            step(D + 2);
            chk("walk_early_idx", 32'(if_a.index), 32'(exp_prev));
            chk("walk_early_chg", 32'(if_a.changed), 32'd0);
            step(1);
            chk("walk_idx_a", 32'(if_a.index), 32'(i));
            chk("walk_idx_b", 32'(if_b.index), 32'(i));
            chk("walk_idx_c", 32'(if_c.index), 32'(i));
            chk("walk_valid", {29'd0, if_a.valid, if_a.multi, if_a.none}, 32'b100);
            chk("walk_chg_now", 32'(if_a.changed), 32'd1);
            step(3);
            chk("walk_chg_cnt", 32'(chg_a), 32'd1);
            exp_prev = 3'(i);
        end

        // Two bits set: priority direction and strict hold.
        clr_chg();
        set_sw(8'h24);
        step(10);
        chk("m24_idx_a", 32'(if_a.index), 32'd5);
        chk("m24_flags_a", {29'd0, if_a.valid, if_a.multi, if_a.none}, 32'b010);
        chk("m24_idx_b", 32'(if_b.index), 32'd2);
        chk("m24_idx_c", 32'(if_c.index), 32'd7);
        chk("m24_multi_c", 32'(if_c.multi), 32'd1);
        chk("m24_chg_c", 32'(chg_c), 32'd1);

        clr_chg();
        set_sw(8'h08);
        step(10);
        chk("s08_idx_c", 32'(if_c.index), 32'd3);
        chk("s08_valid_c", 32'(if_c.valid), 32'd1);

        clr_chg();
        set_sw(8'h48);
        step(10);
        chk("s48_idx_c", 32'(if_c.index), 32'd3);
        chk("s48_flags_c", {29'd0, if_c.valid, if_c.multi, if_c.none}, 32'b010);
        chk("s48_chg_c", 32'(chg_c), 32'd1);
        chk("s48_idx_a", 32'(if_a.index), 32'd6);
        chk("s48_idx_b", 32'(if_b.index), 32'd3);

        // Dropping to zero keeps the last index.
        set_sw(8'h02);
        step(10);
        chk("z02_idx_a", 32'(if_a.index), 32'd1);
        clr_chg();
        set_sw(8'h00);
        step(10);
        chk("z00_flags_a", {29'd0, if_a.valid, if_a.multi, if_a.none}, 32'b001);
        chk("z00_idx_a", 32'(if_a.index), 32'd1);
        chk("z00_idx_b", 32'(if_b.index), 32'd1);
        chk("z00_idx_c", 32'(if_c.index), 32'd1);
        chk("z00_chg_a", 32'(chg_a), 32'd1);

        // Reset mid-settle discards the candidate; count restarts from release.
        set_sw(8'h80);
        step(2);
        rst = 1'b1;
        step(2);
        chk_reset_vals("mid_rst");
        rst = 1'b0;
        step(D + 2);
        chk("rel_early_idx", 32'(if_a.index), 32'd0);
        chk("rel_early_none", 32'(if_a.none), 32'd1);
        step(1);
        chk("rel_idx_a", 32'(if_a.index), 32'd7);
        chk("rel_idx_b", 32'(if_b.index), 32'd7);
        chk("rel_idx_c", 32'(if_c.index), 32'd7);
        chk("rel_valid_a", 32'(if_a.valid), 32'd1);
        step(3);

        chk("chg_consecutive", 32'(consec), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
